// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t       : E-stage ALU operand source select.
//   memwait_state_t : data-memory wait FSM states.
//   WAIT_W          : width of the memory-wait cycle counter.
//   fwd_select()    : forwarding priority rule (M over W, register 0 never matches).
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MEMWAIT = 1'b1
    } memwait_state_t;

    localparam int WAIT_W = 8;

    // The younger instruction in M wins over W because it holds the newer value.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] src,
        input logic [4:0] wreg_m,
        input logic       rw_m,
        input logic [4:0] wreg_w,
        input logic       rw_w
    );
        fwd_sel_t sel;
        if ((src != 5'd0) && (src == wreg_m) && rw_m) begin
            sel = FWD_MEM;
        end else if ((src != 5'd0) && (src == wreg_w) && rw_w) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk   : clock
//   reset : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over inc
//   inc   : add one this cycle unless already at all-ones
//   count : registered count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
// Inputs : per-stage register numbers and controls (D/E/M/W), dmem_ready from
//          the data memory, cnt_clr to clear the performance counters.
// Outputs: forwarding selects (forwardAD/BD/AE/BE), stall and flush enables,
//          sticky mem_timeout flag, and saturating performance counters
//          stall_cycles / loaduse_events / memwait_cycles.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             memwriteM,
    input  logic             branchD,
    input  logic             pcsrcD,
    input  logic             jumpD,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] loaduse_events,
    output logic [CNT_W-1:0] memwait_cycles
);

    logic              lwstall_s;
    logic              branchstall_s;
    logic              memstall_s;
    logic              stall_fd_s;
    memwait_state_t    state_r;
    memwait_state_t    state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic              timeout_set_s;
    logic              mem_timeout_r;

    // Forwarding selects for the E-stage ALU and the D-stage branch comparator.
    always_comb begin
        forwardAE = fwd_select(rsE, writeregM, regwriteM, writeregW, regwriteW);
        forwardBE = fwd_select(rtE, writeregM, regwriteM, writeregW, regwriteW);
        forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
        forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
    end

    // Hazard detection and the resulting stall/flush enables. A memory stall
    // holds E, so the load-use/branch bubble into E must not be inserted then.
    always_comb begin
        lwstall_s     = memtoregE && ((rsD == rtE) || (rtD == rtE));
        branchstall_s = branchD &&
                        ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                         (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
        memstall_s    = (memtoregM || memwriteM) && !dmem_ready;
        stall_fd_s    = lwstall_s || branchstall_s || memstall_s;
        stallF        = stall_fd_s;
        stallD        = stall_fd_s;
        stallE        = memstall_s;
        stallM        = memstall_s;
        flushE        = (lwstall_s || branchstall_s) && !memstall_s;
        flushW        = memstall_s;
        flushD        = (pcsrcD || jumpD) && !stall_fd_s;
    end

    // Memory-wait FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory-wait FSM next state: leave MEMWAIT once the access completes or vanishes.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = memstall_s ? MEMWAIT : IDLE;
            MEMWAIT: state_next_s = memstall_s ? MEMWAIT : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Memory-wait FSM outputs: next wait count and the timeout trigger, which
    // fires on the edge where the count reaches the limit and the wait persists.
    always_comb begin
        wait_cnt_next_s = {WAIT_W{1'b0}};
        timeout_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                wait_cnt_next_s = {WAIT_W{1'b0}};
                timeout_set_s   = 1'b0;
            end
            MEMWAIT: begin
                if (wait_cnt_r != {WAIT_W{1'b1}}) begin
                    wait_cnt_next_s = wait_cnt_r + 8'd1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r;
                end
                timeout_set_s = memstall_s && (wait_cnt_next_s == WAIT_W'(MEM_TIMEOUT));
            end
            default: begin
                wait_cnt_next_s = {WAIT_W{1'b0}};
                timeout_set_s   = 1'b0;
            end
        endcase
    end

    // Wait counter and sticky timeout flag; only reset clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            wait_cnt_r    <= wait_cnt_next_s;
            mem_timeout_r <= mem_timeout_r || timeout_set_s;
        end
    end

    assign mem_timeout = mem_timeout_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (stall_fd_s),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_loaduse_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (lwstall_s && !memstall_s),
        .count (loaduse_events)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (memstall_s),
        .count (memwait_cycles)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver applies each cycle's inputs and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_hazard_unit;

    localparam int CNT_W = 2;
    localparam int MT    = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM;
    logic branchD, pcsrcD, jumpD, dmem_ready, cnt_clr;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic forwardAD, forwardBD, mem_timeout;
    logic [1:0] forwardAE, forwardBE;
    logic [CNT_W-1:0] stall_cycles, loaduse_events, memwait_cycles;

    hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
        .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .loaduse_events(loaduse_events),
        .memwait_cycles(memwait_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic rwE, rwM, rwW, mrE, mrM, mwM, brD, pcD, jD, rdy, clr, rst;
    } stim_t;

    typedef struct {
        int fAE, fBE, fAD, fBD;
        int sF, sD, sE, sM, fD, fE, fW;
        int to, sc, lu, mw;
    } exp_t;

    exp_t scb_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model state (values visible during the current cycle)
    int  m_sc = 0, m_lu = 0, m_mw = 0, m_run = 0;
    bit  m_to = 1'b0;
    bit  p_valid = 1'b0, p_rst = 1'b0, p_clr = 1'b0;
    bit  p_stall = 1'b0, p_lu = 1'b0, p_mem = 1'b0;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic int fwd_ref(input logic [4:0] src, input stim_t s);
        if (src != 5'd0 && s.rwM && src == s.wM) return 2;
        if (src != 5'd0 && s.rwW && src == s.wW) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle: settle the previous edge in the model, drive, predict, push
    task automatic cycle(input stim_t s);
        exp_t e;
        bit lw, br, mem, stl;
        @(posedge clk);
        #2;
        if (p_valid && p_rst) begin
            if (p_mem && m_run >= MT) m_to = 1'b1;
            m_run = p_mem ? m_run + 1 : 0;
            if (p_clr) begin
                m_sc = 0; m_lu = 0; m_mw = 0;
            end else begin
                if (p_stall) m_sc = sat_inc(m_sc);
                if (p_lu)    m_lu = sat_inc(m_lu);
                if (p_mem)   m_mw = sat_inc(m_mw);
            end
        end
        rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
        writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
        regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
        memtoregE = s.mrE; memtoregM = s.mrM; memwriteM = s.mwM;
        branchD = s.brD; pcsrcD = s.pcD; jumpD = s.jD;
        dmem_ready = s.rdy; cnt_clr = s.clr; reset = s.rst;
        if (!s.rst) begin
            m_sc = 0; m_lu = 0; m_mw = 0; m_run = 0; m_to = 1'b0;
        end
        lw  = s.mrE && (s.rsD == s.rtE || s.rtD == s.rtE);
        br  = s.brD && ((s.rwE && (s.wE == s.rsD || s.wE == s.rtD)) ||
                        (s.mrM && (s.wM == s.rsD || s.wM == s.rtD)));
        mem = (s.mrM || s.mwM) && !s.rdy;
        stl = lw || br || mem;
        e.fAE = fwd_ref(s.rsE, s);
        e.fBE = fwd_ref(s.rtE, s);
        e.fAD = (s.rsD != 5'd0 && s.rwM && s.rsD == s.wM) ? 1 : 0;
        e.fBD = (s.rtD != 5'd0 && s.rwM && s.rtD == s.wM) ? 1 : 0;
        e.sF = stl; e.sD = stl; e.sE = mem; e.sM = mem;
        e.fE = (lw || br) && !mem;
        e.fW = mem;
        e.fD = (s.pcD || s.jD) && !stl;
        e.to = m_to; e.sc = m_sc; e.lu = m_lu; e.mw = m_mw;
        scb_q.push_back(e);
        p_valid = 1'b1; p_rst = s.rst; p_clr = s.clr;
        p_stall = stl; p_lu = lw && !mem; p_mem = mem;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle at negedge
    always @(negedge clk) begin
        exp_t e;
        if (scb_q.size() > 0) begin
            e = scb_q.pop_front();
            chk("forwardAE", 32'(forwardAE), e.fAE);
            chk("forwardBE", 32'(forwardBE), e.fBE);
            chk("forwardAD", 32'(forwardAD), e.fAD);
            chk("forwardBD", 32'(forwardBD), e.fBD);
            chk("stallF", 32'(stallF), e.sF);
            chk("stallD", 32'(stallD), e.sD);
            chk("stallE", 32'(stallE), e.sE);
            chk("stallM", 32'(stallM), e.sM);
            chk("flushD", 32'(flushD), e.fD);
            chk("flushE", 32'(flushE), e.fE);
            chk("flushW", 32'(flushW), e.fW);
            chk("mem_timeout", 32'(mem_timeout), e.to);
            chk("stall_cycles", 32'(stall_cycles), e.sc);
            chk("loaduse_events", 32'(loaduse_events), e.lu);
            chk("memwait_cycles", 32'(memwait_cycles), e.mw);
        end
    end

    function automatic stim_t quiet();
        stim_t s;
        s.rsD = 5'd0; s.rtD = 5'd0; s.rsE = 5'd0; s.rtE = 5'd0;
        s.wE = 5'd0; s.wM = 5'd0; s.wW = 5'd0;
        s.rwE = 1'b0; s.rwM = 1'b0; s.rwW = 1'b0; s.mrE = 1'b0; s.mrM = 1'b0;
        s.mwM = 1'b0; s.brD = 1'b0; s.pcD = 1'b0; s.jD = 1'b0;
        s.rdy = 1'b1; s.clr = 1'b0; s.rst = 1'b1;
        // Distinct register numbers so nothing matches by accident
        s.rsD = 5'd20; s.rtD = 5'd21; s.rsE = 5'd22; s.rtE = 5'd23;
        s.wE = 5'd24; s.wM = 5'd25; s.wW = 5'd26;
        return s;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int hold = 0;
        reset = 1'b0;
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM} = '0;
        {branchD, pcsrcD, jumpD, cnt_clr} = '0;
        dmem_ready = 1'b1;

        // Reset with stalling inputs: registered outputs must read zero
        s = quiet(); s.rst = 1'b0; s.mrM = 1'b1; s.rdy = 1'b0;
        cycle(s); cycle(s);

        // Forwarding priority M over W, then register 0
        s = quiet(); s.rwM = 1'b1; s.wM = 5'd5; s.rwW = 1'b1; s.wW = 5'd5; s.rsE = 5'd5;
        cycle(s);
        s.rsE = 5'd0; cycle(s);
        s.rsE = 5'd7; s.wW = 5'd7; s.rtE = 5'd5; cycle(s);

        // Load-use hazard
        s = quiet(); s.mrE = 1'b1; s.rtE = 5'd8; s.rsD = 5'd8;
        cycle(s);
        cycle(quiet());

        // Branch stall, then M-forward resolves it
        s = quiet(); s.brD = 1'b1; s.rwE = 1'b1; s.wE = 5'd3; s.rtD = 5'd3;
        cycle(s);
        s = quiet(); s.brD = 1'b1; s.rwM = 1'b1; s.wM = 5'd3; s.rtD = 5'd3;
        cycle(s);
        s = quiet(); s.jD = 1'b1; cycle(s);

        // Memory wait with a concurrent load-use hazard, long enough to time out
        s = quiet(); s.mrM = 1'b1; s.rdy = 1'b0; s.mrE = 1'b1; s.rtE = 5'd8; s.rsD = 5'd8;
        for (int i = 0; i < 4; i++) cycle(s);
        s = quiet(); s.mrM = 1'b1; cycle(s);
        cycle(quiet());
        s = quiet(); s.clr = 1'b1; cycle(s);
        cycle(quiet());
        s = quiet(); s.rst = 1'b0; cycle(s);
        cycle(quiet());

        // Saturation and clear-priority on the 2-bit counters
        s = quiet(); s.mrE = 1'b1; s.rtE = 5'd9; s.rtD = 5'd9;
        for (int i = 0; i < 5; i++) cycle(s);
        s.clr = 1'b1; cycle(s);
        cycle(quiet());

        // Memory wait that ends just short of the timeout
        s = quiet(); s.mwM = 1'b1; s.rdy = 1'b0;
        for (int i = 0; i < MT; i++) cycle(s);
        cycle(quiet());

        // Randomised traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
            s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
            s.wE = 5'($urandom_range(0, 3)); s.wM = 5'($urandom_range(0, 3));
            s.wW = 5'($urandom_range(0, 3));
            s.rwE = 1'($urandom); s.rwM = 1'($urandom); s.rwW = 1'($urandom);
            s.mrE = 1'($urandom); s.mrM = 1'($urandom); s.mwM = 1'($urandom);
            s.brD = 1'($urandom); s.pcD = 1'($urandom); s.jD = 1'($urandom);
            s.clr = ($urandom_range(0, 49) == 0);
            s.rst = ($urandom_range(0, 149) != 0);
            if (hold > 0) begin
                s.rdy = 1'b0; s.mrM = 1'b1; hold--;
            end else if ($urandom_range(0, 7) == 0) begin
                s.rdy = 1'b0; hold = $urandom_range(1, 6);
            end else begin
                s.rdy = 1'b1;
            end
            cycle(s);
        end
        cycle(quiet());
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
